// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StWaitHigh
    } rx_state_e;

    // Sample offsets relative to the bit midpoint (OVERSAMPLE/2).
    localparam int SampleOffEarly = -1;
    localparam int SampleOffMid   = 0;
    localparam int SampleOffLate  = 1;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Widest supported word is 9 bits; narrower words are zero-extended by the caller.
    function automatic logic parity_of(input logic [8:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO for received words; head word is held while empty.
module uart_rx_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [Width-1:0]         data_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o
);
    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]    count_q, count_d;
    logic [Width-1:0] hold_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PtrW+1)'(Depth));
    assign do_pop  = pop_i && !empty_o;
    // A push into a full FIFO is accepted only when a pop frees a slot on the same edge.
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = empty_o ? hold_q : mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            hold_q  <= data_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with 3-sample majority vote and output FIFO.
// Optional parity checking is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                          baud_clk,
    input  logic                          reset_n,
    input  logic                          rx_data_in,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int unsigned CntW = $clog2(OVERSAMPLE);
    localparam int unsigned BitW = 4;
    localparam logic [CntW-1:0] SampleA = CntW'(int'(OVERSAMPLE / 2) + SampleOffEarly);
    localparam logic [CntW-1:0] SampleB = CntW'(int'(OVERSAMPLE / 2) + SampleOffMid);
    localparam logic [CntW-1:0] SampleC = CntW'(int'(OVERSAMPLE / 2) + SampleOffLate);
    localparam logic [CntW-1:0] BitEnd  = CntW'(OVERSAMPLE - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 ||
        STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || PARITY_ODD > 1) begin : g_param_err
        $error("uart_rx_os: illegal parameter set");
    end

    logic [1:0]           sync_q;
    logic                 rxs;
    rx_state_e            state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [BitW-1:0]      bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 samp_a_q, samp_b_q;
    logic                 maj, at_dec, at_end;
    logic                 push, fe, pe;
    logic                 fifo_full, fifo_empty, pop;

    assign rxs    = sync_q[1];
    assign maj    = majority3(samp_a_q, samp_b_q, rxs);
    assign at_dec = (cnt_q == SampleC);
    assign at_end = (cnt_q == BitEnd);

`ifdef UART_RX_PARITY_EN
    localparam logic ParityOdd = 1'(PARITY_ODD);
    logic perr_q, perr_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        push    = 1'b0;
        fe      = 1'b0;
        pe      = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d  = perr_q;
`endif
        if (state_q != StIdle) cnt_d = at_end ? '0 : cnt_q + 1'b1;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                bit_d = '0;
`ifdef UART_RX_PARITY_EN
                perr_d = 1'b0;
`endif
                // The tick that sees the low line counts as sample slot 0.
                if (!rxs) begin
                    state_d = StStart;
                    cnt_d   = CntW'(1);
                end
            end
            StStart: begin
                if (at_dec && maj) state_d = StIdle;
                else if (at_end)   state_d = StData;
            end
            StData: begin
                if (at_dec) shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
                if (at_end) begin
                    if (bit_q == BitW'(DATA_BITS - 1)) begin
                        bit_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (at_dec) perr_d = ((parity_of(9'(shreg_q)) ^ maj) != ParityOdd);
                if (at_end) state_d = StStop;
            end
`endif
            StStop: begin
                if (at_dec && !maj) begin
                    fe      = 1'b1;
                    state_d = StWaitHigh;
                end else if (at_dec && bit_q == BitW'(STOP_BITS - 1)) begin
                    // Leave at the decision tick so an early next start bit is caught.
                    state_d = StIdle;
`ifdef UART_RX_PARITY_EN
                    if (perr_q) pe = 1'b1;
                    else        push = 1'b1;
`else
                    push = 1'b1;
`endif
                end else if (at_end) begin
                    bit_d = bit_q + 1'b1;
                end
            end
            StWaitHigh: begin
                if (rxs) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= 2'b11;
            state_q  <= StIdle;
            cnt_q    <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            samp_a_q <= 1'b1;
            samp_b_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_q   <= 1'b0;
`endif
        end else begin
            sync_q  <= {sync_q[0], rx_data_in};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            if (cnt_q == SampleA) samp_a_q <= rxs;
            if (cnt_q == SampleB) samp_b_q <= rxs;
`ifdef UART_RX_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    assign pop      = rx_valid && rx_ready;
    assign rx_valid = !fifo_empty;

    uart_rx_fifo #(
        .Width (DATA_BITS),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (baud_clk),
        .rst_ni  (reset_n),
        .push_i  (push),
        .data_i  (shreg_q),
        .pop_i   (pop),
        .data_o  (rx_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign frame_err  = fe;
    assign overrun    = push && fifo_full && !pop;
`ifdef UART_RX_PARITY_EN
    assign parity_err = pe;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed self-checking bench for uart_rx_os (8 data bits, 16x, 1 stop, depth 4).
module tb_uart_rx_os;
    localparam int OS = 16;

    logic       baud_clk = 1'b0;
    logic       reset_n  = 1'b1;
    logic       rx_line  = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, parity_err, overrun;
    logic [2:0] fifo_count;

    int total = 0;
    int bad   = 0;
    int fe_n  = 0;
    int pe_n  = 0;
    int ov_n  = 0;
    int fe0, ov0;
    logic [7:0] popq[$];

    uart_rx_os #(
        .DATA_BITS  (8),
        .OVERSAMPLE (OS),
        .STOP_BITS  (1),
        .FIFO_DEPTH (4),
        .PARITY_ODD (0)
    ) dut (
        .baud_clk   (baud_clk),
        .reset_n    (reset_n),
        .rx_data_in (rx_line),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .fifo_count (fifo_count)
    );

    always #5 baud_clk = ~baud_clk;

    // Mid-cycle observer: pulse counts and the stream of accepted words.
    always @(negedge baud_clk) begin
        if (frame_err)  fe_n++;
        if (parity_err) pe_n++;
        if (overrun)    ov_n++;
        if (rx_valid && rx_ready) popq.push_back(rx_data);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge baud_clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic v);
        rx_line = v;
        ticks(OS);
    endtask

    // Drives a frame and returns in the tick where the last stop bit is decided.
    task automatic send_to_push(input logic [7:0] d, input logic stop_v);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(^d);
`endif
        rx_line = stop_v;
        ticks(11);
    endtask

    task automatic send_frame(input logic [7:0] d);
        send_to_push(d, 1'b1);
        ticks(5);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_par_frame(input logic [7:0] d, input logic pbit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(pbit);
        drive_bit(1'b1);
    endtask
`endif

    initial begin
        // Reset state
        #2 reset_n = 1'b0;
        ticks(3);
        check("rst_data", rx_data, 8'h00);
        check("rst_valid", rx_valid, 1'b0);
        check("rst_count", fifo_count, 3'd0);
        check("rst_fe", frame_err, 1'b0);
        check("rst_pe", parity_err, 1'b0);
        check("rst_ov", overrun, 1'b0);
        reset_n = 1'b1;
        ticks(5);

        // Nominal 0xA5 with consumer always ready
        rx_ready = 1'b1;
        popq.delete();
        send_to_push(8'hA5, 1'b1);
        check("nom_valid_s153", rx_valid, 1'b0);
        ticks(1);
        check("nom_valid_s154", rx_valid, 1'b1);
        check("nom_data", rx_data, 8'hA5);
        ticks(1);
        check("nom_valid_s155", rx_valid, 1'b0);
        check("nom_data_hold", rx_data, 8'hA5);
        ticks(3);
        check("nom_no_errs", fe_n + pe_n + ov_n, 0);

        // Start glitch then 0x3C
        popq.delete();
        rx_line = 1'b0;
        ticks(4);
        rx_line = 1'b1;
        ticks(40);
        check("glitch_nopush", popq.size(), 0);
        check("glitch_noerr", fe_n, 0);
        send_frame(8'h3C);
        ticks(4);
        check("glitch_next_n", popq.size(), 1);
        check("glitch_next_d", popq[0], 8'h3C);

        // Framing error followed by a break
        popq.delete();
        fe0 = fe_n;
        send_to_push(8'h55, 1'b0);
        check("fe_pulse", frame_err, 1'b1);
        ticks(1);
        check("fe_width", frame_err, 1'b0);
        ticks(4 + 40);
        rx_line = 1'b1;
        ticks(20);
        check("fe_once", fe_n - fe0, 1);
        check("fe_count", fifo_count, 3'd0);
        check("fe_nopush", popq.size(), 0);
        send_frame(8'h81);
        ticks(4);
        check("fe_next_n", popq.size(), 1);
        check("fe_next_d", popq[0], 8'h81);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones, so parity bit 1 is correct
        popq.delete();
        send_par_frame(8'h07, 1'b0);
        ticks(4);
        check("par_err", pe_n, 1);
        check("par_nopush", popq.size(), 0);
        send_par_frame(8'h07, 1'b1);
        ticks(4);
        check("par_ok_err", pe_n, 1);
        check("par_ok_n", popq.size(), 1);
        check("par_ok_d", popq[0], 8'h07);
`endif

        // Overrun with a stalled consumer
        rx_ready = 1'b0;
        popq.delete();
        ov0 = ov_n;
        send_frame(8'h01);
        send_frame(8'h02);
        send_frame(8'h03);
        send_frame(8'h04);
        check("ovr_full", fifo_count, 3'd4);
        check("ovr_head", rx_data, 8'h01);
        check("ovr_none_yet", ov_n - ov0, 0);
        send_to_push(8'h05, 1'b1);
        check("ovr_pulse", overrun, 1'b1);
        ticks(1);
        check("ovr_width", overrun, 1'b0);
        check("ovr_kept", fifo_count, 3'd4);
        ticks(4);
        // Push into a full FIFO in the same tick as a pop
        send_to_push(8'h06, 1'b1);
        rx_ready = 1'b1;
        #1;
        check("pp_no_ovr", overrun, 1'b0);
        ticks(1);
        rx_ready = 1'b0;
        check("pp_count", fifo_count, 3'd4);
        check("pp_head", rx_data, 8'h02);
        ticks(4);
        rx_ready = 1'b1;
        ticks(6);
        check("ovr_total", ov_n - ov0, 1);
        check("drain_n", popq.size(), 5);
        check("drain_0", popq[0], 8'h01);
        check("drain_1", popq[1], 8'h02);
        check("drain_2", popq[2], 8'h03);
        check("drain_3", popq[3], 8'h04);
        check("drain_4", popq[4], 8'h06);
        check("drain_cnt", fifo_count, 3'd0);

        // Reset in the middle of a frame with a word already queued
        rx_ready = 1'b0;
        send_frame(8'h11);
        check("mid_pre_cnt", fifo_count, 3'd1);
        popq.delete();
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        rx_line = 1'b1;
        ticks(8);
        reset_n = 1'b0;
        #1;
        check("mid_valid", rx_valid, 1'b0);
        check("mid_count", fifo_count, 3'd0);
        check("mid_data", rx_data, 8'h00);
        ticks(3);
        reset_n = 1'b1;
        ticks(200);
        check("mid_nopush", fifo_count, 3'd0);
        rx_ready = 1'b1;
        send_frame(8'h5A);
        ticks(4);
        check("mid_next_n", popq.size(), 1);
        check("mid_next_d", popq[0], 8'h5A);
        check("end_frame_errs", fe_n, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
